// File: rtl/imem_loader.sv
// Instruction-memory writer: loads a length-prefixed byte stream, verifies an XOR checksum,
// optionally pads the remaining words (LOADER_FILL_EN) and holds the CPU in reset until done.
module imem_loader #(
  parameter int                 ADDR_W    = 4,
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  FILL_WORD = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              in_ready_s;
  logic              accept_s;
  logic              len_ok_s;

  assign in_ready_s = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept_s   = in_valid & in_ready_s;
  assign len_ok_s   = (in_data != '0) && (32'(in_data) <= 32'(DEPTH));

  // Next-state, counters and the registered write port.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_LEN;
          len_d     = '0;
          idx_d     = '0;
          chk_d     = '0;
          wr_data_d = FILL_WORD;  // idle write data parks at the pad value
        end else begin
          state_d = state_q;
        end
      end
      S_LEN: begin
        if (accept_s) begin
          if (len_ok_s) begin
            len_d   = (ADDR_W+1)'(in_data);
            state_d = S_DATA;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = in_data;
          chk_d     = chk_q ^ in_data;
          idx_d     = idx_q + ONE_C;
          if ((idx_q + ONE_C) == len_q) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (accept_s) begin
          if (in_data != chk_q) begin
            state_d = S_ERR;
          end else begin
`ifdef LOADER_FILL_EN
            state_d = (len_q == DEPTH_C) ? S_DONE : S_FILL;
`else
            state_d = S_DONE;
`endif
          end
        end else begin
          state_d = S_CHK;
        end
      end
`ifdef LOADER_FILL_EN
      S_FILL: begin
        // idx_q already equals N here, so padding continues from the first unloaded word
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q[ADDR_W-1:0];
        wr_data_d = FILL_WORD;
        idx_d     = idx_q + ONE_C;
        if (idx_q == (DEPTH_C - ONE_C)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FILL;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = in_ready_s || (state_q == S_FILL);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpu_reset = (state_q != S_DONE);
  assign checksum  = chk_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface. The CPU fetch path only reads instruction memory; this block fills it from a byte stream with a valid/ready handshake, checks an XOR checksum, and pads unused words. It holds the CPU in reset until a load completes cleanly, and sits beside cpu_top, driving the memory write port and the CPU reset.

Parameters:
ADDR_W, 4, instruction memory address width; DEPTH = 2**ADDR_W words
DATA_W, 8, instruction word / stream byte width
FILL_WORD, 8'h00, value written to words not covered by the load

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin a load; honoured only in IDLE, DONE, ERR
in_valid  in  1  stream byte valid
in_data  in  DATA_W  stream byte
in_ready  out  1  loader can accept in_data this cycle
wr_en  out  1  memory write strobe, registered
wr_addr  out  ADDR_W  memory write address, registered
wr_data  out  DATA_W  memory write data, registered
cpu_reset  out  1  active-high hold to the CPU reset; 1 = CPU held
busy  out  1  state is LEN, DATA, CHK or FILL
done  out  1  load finished, checksum OK
error  out  1  load aborted: bad length or checksum mismatch
checksum  out  DATA_W  running XOR of the data bytes accepted so far

Behaviour:
- Reset (reset==0 at clk edge) forces:
  - state IDLE
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0
  - cpu_reset=1, busy=0, done=0, error=0, checksum=0
  - Memory contents are not cleared; a reset mid-load leaves a partial image and the CPU held.
- Accept condition: in_valid & in_ready. in_ready=1 only in LEN, DATA, CHK, and does not depend on in_valid.
- cpu_reset=0 only in DONE; 1 in every other state.
- IDLE: on start -> LEN; checksum, index and length are cleared.
- LEN: the accepted byte is the length N.
  - Valid range 1..DEPTH -> DATA.
  - 0 or >DEPTH -> ERR.
- DATA: each accepted byte B at index i (0..N-1):
  - the next cycle shows wr_en=1, wr_addr=i, wr_data=B;
  - checksum <= checksum ^ B.
  - After the Nth byte -> CHK.
- CHK: the accepted byte is compared with checksum.
  - Equal -> FILL, or DONE if N==DEPTH.
  - Unequal -> ERR; no fill is performed.
- FILL: one write per cycle, addresses N..DEPTH-1, data FILL_WORD, wr_en=1 on consecutive cycles.
  - Takes the state to DONE on the edge that registers the last fill write.
  - Timing: checksum accepted at edge T -> first fill write visible after T+1, last after T+DEPTH-N, done=1 after T+DEPTH-N.
- wr_en is 0 in every cycle not listed above. Each address is written at most once per load.
- DONE: done=1, cpu_reset=0. start -> LEN; cpu_reset=1 and done=0 from the next edge.
- ERR: error=1, cpu_reset=1. start -> LEN, error=0.
- start is ignored while busy. in_valid is ignored outside LEN, DATA, CHK.
- Index and fill counters are ADDR_W+1 bits wide; writes never wrap past DEPTH-1.

Optional Feature:
LOADER_FILL_EN
- Defined: FILL state present, as described above.
- Undefined: FILL is removed and a checksum match goes directly to DONE on the next edge. Words N..DEPTH-1 keep their previous contents. FILL_WORD is unused.

Test Plan:
- Nominal load, fill on: reset low 2 cycles, start, stream 0x03, 0x51, 0x62, 0x13, 0x20 -> expected:
  - writes (0,0x51), (1,0x62), (2,0x13), then addresses 3..15 = 0x00 on 13 consecutive cycles;
  - done=1, cpu_reset=0, checksum=0x20.
- Full load: start, N=0x10, 16 bytes 0x00..0x0F, checksum 0x00 -> expected: 16 writes with addr==data, no fill writes, DONE the edge after the checksum byte.
- Bad checksum: start, 0x02, 0xAA, 0x55, 0x00 (expected 0xFF) -> expected: error=1, cpu_reset=1, no fill writes. A following start clears error and in_ready returns in LEN.
- Bad length: start, length 0x00, and separately 0x11 -> expected: ERR the next edge, no wr_en pulses.
- Backpressure/stall: in_valid toggled 1-0-1 and start pulsed during DATA -> expected: only accepted bytes are written, in sequence, and start has no effect.
- Reset mid-load: reset=0 after 2 of 4 data bytes -> expected: IDLE, cpu_reset=1, checksum=0, wr_en=0; a fresh load then succeeds.
- Fill off: the nominal stream with LOADER_FILL_EN undefined -> expected: exactly 3 writes and done on the edge after 0x20.
